bfm_ahbslave_mem: RTL and testbench
===================================

# bfm_ahbslave_mem

Parametrised AHB-Lite slave memory model for simulation benches: a successor to the fixed 32-bit, zero-wait AHB slave BFM. It adds configurable data width, programmable wait states, per-byte-lane writes from HSIZE/HADDR, and a two-cycle ERROR response for illegal or fenced accesses. Transfer counters are exposed so testbenches can check traffic. It sits on a bus-matrix slave port in place of a peripheral during system-level verification.

## Interface
- AWIDTH, 10: HADDR width in bits.
- DWIDTH, 32: data width, 32 or 64.
- DEPTH, 256: memory depth in DWIDTH words; word index wraps modulo DEPTH.
- WAITS, 0: wait states (0–15) inserted on every OKAY transfer.
- ERR_LO, 0 / ERR_HI, 0: byte-address range [ERR_LO, ERR_HI) answered with ERROR; empty when equal.
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESETN  in  1  reset, synchronous, active-low.
- HSEL, HWRITE, HREADYIN, HMASTLOCK  in  1  standard AHB-Lite controls.
- HADDR  in  AWIDTH  byte address.
- HTRANS  in  2;  HSIZE  in  3;  HBURST  in  3;  HPROT  in  4.
- HWDATA  in  DWIDTH  write data (data phase).
- HRDATA  out  DWIDTH  read data, registered.
- HREADYOUT  out  1  transfer-done / wait.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- WR_COUNT, RD_COUNT  out  16 each  completed OKAY write/read transfers, wrapping.
- ERR_COUNT  out  8  ERROR responses issued, saturating at 255.

## Operation
- Accept condition: HSEL & HREADYIN & HTRANS[1] (NONSEQ/SEQ). On accept, latch HADDR, HWRITE, HSIZE.
- IDLE/BUSY transfers, or cycles with HSEL low: zero-wait OKAY, no memory access.
- Error check at accept:
  - HSIZE > log2(DWIDTH/8), or
  - address not aligned to 2^HSIZE, or
  - address in [ERR_LO, ERR_HI).
  - Any of these gives ERROR.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: on a legal accept, go to WAIT when WAITS > 0, else DATA. On an error accept, go to ERR1.
  - WAIT: HREADYOUT = 0; a down-counter loads WAITS-1; at 0 go to DATA.
  - DATA: HREADYOUT = 1 and the transfer completes. If a new accept occurs this cycle (pipelined), go directly to WAIT/DATA/ERR1; otherwise go to IDLE.
  - ERR1: HRESP = 1, HREADYOUT = 0; go to ERR2.
  - ERR2: HRESP = 1, HREADYOUT = 1. A new accept is evaluated as in DATA.
- Write, in the DATA cycle:
  - Bytes selected by HSIZE and the latched address low bits (little-endian) take HWDATA lanes.
  - All other bytes are unchanged. Word index = addr[AWIDTH-1:log2(DWIDTH/8)] mod DEPTH.
- Read: the full word is loaded into HRDATA one cycle before the DATA cycle, so it is valid while HREADYOUT = 1. HRDATA = 0 in all other cycles.
- ERROR transfers never modify memory. HRDATA = 0 during ERROR.
- Counters:
  - WR_COUNT / RD_COUNT increment in the DATA cycle of a write / read.
  - ERR_COUNT increments in ERR2.
- HBURST, HPROT, HMASTLOCK are accepted and ignored. Each beat is treated independently, and the address comes from HADDR, not computed internally.
- Memory contents are zero at time 0 and are not cleared by reset.

## Timing
- Reset (HRESETN low at a clock edge):
  - FSM goes to IDLE.
  - HREADYOUT = 1, HRESP = 0, HRDATA = 0, all counters = 0.
  - A write pending in WAIT is discarded.
- OKAY latency: address phase at cycle n; data phase completes at cycle n+1+WAITS.
- ERROR: exactly 2 data-phase cycles (HREADYOUT 0 then 1) with HRESP high in both.
- Back-to-back: with WAITS = 0, one transfer completes per cycle. Read-after-write to the same word returns the new data (the write commits before the next read's data is loaded).
- HSEL low during WAIT does not abort the current transfer.

## Test plan
- DWIDTH = 32, WAITS = 0: write 0xA5A5_1234 to 0x010, then read 0x010 → HRDATA = 0xA5A5_1234 with HREADYOUT high on the cycle after the read address phase; WR_COUNT = 1, RD_COUNT = 1.
- Byte and halfword lanes: write the word 0x0, then byte 0x77 at 0x002, then halfword 0xBEEF at 0x000 → read 0x000 returns 0x0077_BEEF.
- WAITS = 3: a single read shows HREADYOUT low for exactly 3 cycles, then high with data; a back-to-back write during the wait is held off by HREADYIN low.
- ERR_LO = 0x100, ERR_HI = 0x200:
  - A write to 0x104 gives HRESP = 1 for 2 cycles (HREADYOUT 0 then 1) and leaves memory unchanged.
  - A misaligned word access at 0x002, or HSIZE = 3 with DWIDTH = 32, also returns ERROR.
  - ERR_COUNT = 3 after these three accesses.
- DEPTH = 256, DWIDTH = 64: a write to byte address 0x800 aliases word 0, and reading 0x000 returns that data.
- HRESETN low during the WAIT of a write → the write is not committed, HREADYOUT = 1 the next cycle, and the counters read 0.

Source files
------------

// File: rtl/bfm_ahbslave_mem.sv
// AHB-Lite slave memory model: configurable width, programmable wait states,
// byte-lane writes, and a two-cycle ERROR response for illegal or fenced accesses.
module bfm_ahbslave_mem #(
  parameter int          AWIDTH = 10,
  parameter int          DWIDTH = 32,
  parameter int          DEPTH  = 256,
  parameter int          WAITS  = 0,
  parameter int unsigned ERR_LO = 0,
  parameter int unsigned ERR_HI = 0
) (
  input  logic              HCLK,
  input  logic              HRESETN,
  input  logic              HSEL,
  input  logic              HWRITE,
  input  logic              HREADYIN,
  input  logic              HMASTLOCK,
  input  logic [AWIDTH-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic [DWIDTH-1:0] HWDATA,
  output logic [DWIDTH-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [15:0]       WR_COUNT,
  output logic [15:0]       RD_COUNT,
  output logic [7:0]        ERR_COUNT
);
  localparam int NBYTES = DWIDTH / 8;
  localparam int LB     = $clog2(NBYTES);
  localparam int IDXW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LD = 4'((WAITS > 0) ? WAITS - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
  state_t state, state_nxt;

  logic [DWIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [AWIDTH-1:0] addr_q;
  logic              write_q;
  logic [2:0]        size_q;
  logic [3:0]        wcnt;

  function automatic logic [NBYTES-1:0] lane_mask(input logic [AWIDTH-1:0] a,
                                                  input logic [2:0] sz);
    logic [NBYTES-1:0] m;
    int off;
    int n;
    off = int'(a[LB-1:0]);
    n   = 1 << sz;
    for (int i = 0; i < NBYTES; i++) m[i] = (i >= off) && (i < off + n);
    return m;
  endfunction

  function automatic logic [IDXW-1:0] word_idx(input logic [AWIDTH-1:0] a);
    logic [AWIDTH-1:0] w;
    w = a >> LB;
    return IDXW'(w % AWIDTH'(DEPTH));
  endfunction

  function automatic logic acc_err(input logic [AWIDTH-1:0] a, input logic [2:0] sz);
    logic e;
    e = (int'(sz) > LB);
    for (int i = 0; i < LB; i++) if ((i < int'(sz)) && a[i]) e = 1'b1;
    if ((64'(a) >= 64'(ERR_LO)) && (64'(a) < 64'(ERR_HI))) e = 1'b1;
    return e;
  endfunction

  function automatic logic [DWIDTH-1:0] merge(input logic [DWIDTH-1:0] old_d,
                                              input logic [DWIDTH-1:0] new_d,
                                              input logic [NBYTES-1:0] m);
    logic [DWIDTH-1:0] r;
    r = old_d;
    for (int i = 0; i < NBYTES; i++) if (m[i]) r[8*i +: 8] = new_d[8*i +: 8];
    return r;
  endfunction

  logic              accept, take, acc_bad;
  logic              wr_commit, ld_write;
  logic [AWIDTH-1:0] ld_addr;
  logic [IDXW-1:0]   wr_idx, rd_idx;
  logic [NBYTES-1:0] wr_mask;
  logic [DWIDTH-1:0] rd_word, hrdata_nxt;
  logic              unused_ok;

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};
  assign accept    = HSEL & HREADYIN & HTRANS[1];
  assign take      = accept & HREADYOUT;
  assign acc_bad   = acc_err(HADDR, HSIZE);
  assign HREADYOUT = !((state == S_WAIT) || (state == S_ERR1));
  assign HRESP     = (state == S_ERR1) || (state == S_ERR2);

  assign wr_commit = (state == S_DATA) && write_q;
  assign wr_idx    = word_idx(addr_q);
  assign wr_mask   = lane_mask(addr_q, size_q);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        state_nxt = S_IDLE;
        if (accept) state_nxt = acc_bad ? S_ERR1 : ((WAITS > 0) ? S_WAIT : S_DATA);
      end
      S_WAIT:  if (wcnt == 4'd0) state_nxt = S_DATA;
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read word is loaded on the edge entering DATA; a write committing on that
  // same edge to the same word is forwarded so read-after-write sees new data.
  always_comb begin
    ld_addr    = (state == S_WAIT) ? addr_q : HADDR;
    ld_write   = (state == S_WAIT) ? write_q : HWRITE;
    rd_idx     = word_idx(ld_addr);
    rd_word    = mem[rd_idx];
    if (wr_commit && (wr_idx == rd_idx)) rd_word = merge(rd_word, HWDATA, wr_mask);
    hrdata_nxt = '0;
    if ((state_nxt == S_DATA) && !ld_write) hrdata_nxt = rd_word;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      state     <= S_IDLE;
      HRDATA    <= '0;
      WR_COUNT  <= '0;
      RD_COUNT  <= '0;
      ERR_COUNT <= '0;
      wcnt      <= '0;
    end else begin
      state  <= state_nxt;
      HRDATA <= hrdata_nxt;
      if (state == S_DATA) begin
        if (write_q) WR_COUNT <= WR_COUNT + 16'd1;
        else         RD_COUNT <= RD_COUNT + 16'd1;
      end
      if ((state == S_ERR2) && (ERR_COUNT != 8'hFF)) ERR_COUNT <= ERR_COUNT + 8'd1;
      if (state == S_WAIT) wcnt <= wcnt - 4'd1;
      if (take) wcnt <= WAIT_LD;
    end
  end

  // Address-phase capture and memory array carry no reset.
  always_ff @(posedge HCLK) begin
    if (take) begin
      addr_q  <= HADDR;
      write_q <= HWRITE;
      size_q  <= HSIZE;
    end
    if (wr_commit && HRESETN) mem[wr_idx] <= merge(mem[wr_idx], HWDATA, wr_mask);
  end

endmodule

// File: tb/tb_bfm_ahbslave_mem.sv
// Directed bench for bfm_ahbslave_mem: instance A (32-bit, zero-wait, fenced
// 0x100-0x200) and instance B (64-bit, 3 wait states) share one master bus.
module tb_bfm_ahbslave_mem;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, hsel_a, hsel_b, hwrite, use_b, hreadyin;
  logic [11:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [63:0] hwdata;

  logic [31:0] rdata_a;
  logic        ready_a, resp_a;
  logic [15:0] wrc_a, rdc_a;
  logic [7:0]  errc_a;
  logic [63:0] rdata_b;
  logic        ready_b, resp_b;
  logic [15:0] wrc_b, rdc_b;
  logic [7:0]  errc_b;

  logic        cur_ready, cur_resp;
  logic [63:0] cur_rdata;

  assign hreadyin  = use_b ? ready_b : ready_a;
  assign cur_ready = use_b ? ready_b : ready_a;
  assign cur_resp  = use_b ? resp_b : resp_a;
  assign cur_rdata = use_b ? rdata_b : {32'h0, rdata_a};

  bfm_ahbslave_mem #(.AWIDTH(12), .DWIDTH(32), .DEPTH(256), .WAITS(0),
                     .ERR_LO(32'h100), .ERR_HI(32'h200)) dut_a (
    .HCLK(clk), .HRESETN(rst_n), .HSEL(hsel_a), .HWRITE(hwrite), .HREADYIN(hreadyin),
    .HMASTLOCK(1'b0), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize), .HBURST(3'b000),
    .HPROT(4'b0011), .HWDATA(hwdata[31:0]), .HRDATA(rdata_a), .HREADYOUT(ready_a),
    .HRESP(resp_a), .WR_COUNT(wrc_a), .RD_COUNT(rdc_a), .ERR_COUNT(errc_a)
  );

  bfm_ahbslave_mem #(.AWIDTH(12), .DWIDTH(64), .DEPTH(256), .WAITS(3),
                     .ERR_LO(0), .ERR_HI(0)) dut_b (
    .HCLK(clk), .HRESETN(rst_n), .HSEL(hsel_b), .HWRITE(hwrite), .HREADYIN(hreadyin),
    .HMASTLOCK(1'b0), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize), .HBURST(3'b001),
    .HPROT(4'b0011), .HWDATA(hwdata), .HRDATA(rdata_b), .HREADYOUT(ready_b),
    .HRESP(resp_b), .WR_COUNT(wrc_b), .RD_COUNT(rdc_b), .ERR_COUNT(errc_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Single non-pipelined transfer; returns read data, number of HREADYOUT-low
  // data cycles, HRESP in the first low cycle and HRESP in the completing cycle.
  task automatic xfer(input logic b, input logic [11:0] a, input logic w,
                      input logic [2:0] sz, input logic [63:0] wd,
                      output logic [63:0] rd, output int lo,
                      output logic r_lo, output logic r_end);
    logic done;
    use_b = b;
    @(posedge clk); #1;
    hsel_a = !b; hsel_b = b; haddr = a; hwrite = w; hsize = sz; htrans = 2'b10;
    @(posedge clk); #1;
    hsel_a = 1'b0; hsel_b = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wd;
    lo = 0; r_lo = 1'b0; r_end = 1'b0; rd = '0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (cur_ready) begin
        rd = cur_rdata; r_end = cur_resp; done = 1'b1;
      end else begin
        if (lo == 0) r_lo = cur_resp;
        lo++;
      end
    end
    chk("xfer_done", 64'(done), 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    int          lo;
    logic        rl, re, done;
    rst_n = 1'b0; hsel_a = 1'b0; hsel_b = 1'b0; hwrite = 1'b0; use_b = 1'b0;
    haddr = '0; htrans = 2'b00; hsize = 3'd0; hwdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_a", 64'(ready_a), 64'h1);
    chk("rst_resp_a", 64'(resp_a), 64'h0);
    chk("rst_rdata_a", 64'(rdata_a), 64'h0);
    chk("rst_counts_a", {24'h0, errc_a, wrc_a, rdc_a}, 64'h0);
    chk("rst_ready_b", 64'(ready_b), 64'h1);
    chk("rst_rdata_b", rdata_b, 64'h0);

    // Instance A: basic write then read
    xfer(1'b0, 12'h010, 1'b1, 3'd2, 64'hA5A51234, rd, lo, rl, re);
    chk("wr_lat", 64'(lo), 64'd0);
    chk("wr_resp", 64'(re), 64'h0);
    xfer(1'b0, 12'h010, 1'b0, 3'd2, 64'h0, rd, lo, rl, re);
    chk("rd_lat", 64'(lo), 64'd0);
    chk("rd_data", rd, 64'hA5A51234);
    @(negedge clk);
    chk("wr_count_1", 64'(wrc_a), 64'd1);
    chk("rd_count_1", 64'(rdc_a), 64'd1);

    // Byte and halfword lanes; unused lanes carry junk
    xfer(1'b0, 12'h000, 1'b1, 3'd2, 64'h0, rd, lo, rl, re);
    xfer(1'b0, 12'h002, 1'b1, 3'd0, 64'hDD77CCBB, rd, lo, rl, re);
    xfer(1'b0, 12'h000, 1'b1, 3'd1, 64'h1122BEEF, rd, lo, rl, re);
    xfer(1'b0, 12'h000, 1'b0, 3'd2, 64'h0, rd, lo, rl, re);
    chk("lanes", rd, 64'h0077BEEF);

    // Pipelined read-after-write to the same word
    use_b = 1'b0;
    @(posedge clk); #1;
    hsel_a = 1'b1; haddr = 12'h020; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
    @(posedge clk); #1;
    hwdata = 64'h13572468; hwrite = 1'b0;
    @(negedge clk);
    chk("raw_wr_ready", 64'(ready_a), 64'h1);
    @(posedge clk); #1;
    hsel_a = 1'b0; htrans = 2'b00; hwdata = '0;
    @(negedge clk);
    chk("raw_rd_ready", 64'(ready_a), 64'h1);
    chk("raw_rd_data", 64'(rdata_a), 64'h13572468);

    // Error responses: fenced range, misaligned, oversize
    xfer(1'b0, 12'h104, 1'b1, 3'd2, 64'hDEADBEEF, rd, lo, rl, re);
    chk("fence_lo_cycles", 64'(lo), 64'd1);
    chk("fence_resp1", 64'(rl), 64'h1);
    chk("fence_resp2", 64'(re), 64'h1);
    xfer(1'b0, 12'h002, 1'b1, 3'd2, 64'hFFFFFFFF, rd, lo, rl, re);
    chk("misalign_resp", {62'h0, rl, re}, 64'h3);
    chk("misalign_lo", 64'(lo), 64'd1);
    xfer(1'b0, 12'h000, 1'b1, 3'd3, 64'hFFFFFFFF, rd, lo, rl, re);
    chk("oversize_resp", {62'h0, rl, re}, 64'h3);
    @(negedge clk);
    chk("err_count", 64'(errc_a), 64'd3);
    xfer(1'b0, 12'h504, 1'b0, 3'd2, 64'h0, rd, lo, rl, re);
    chk("fence_mem_alias", rd, 64'h0);
    chk("fence_alias_resp", 64'(re), 64'h0);
    xfer(1'b0, 12'h000, 1'b0, 3'd2, 64'h0, rd, lo, rl, re);
    chk("err_no_write", rd, 64'h0077BEEF);
    xfer(1'b0, 12'h200, 1'b1, 3'd2, 64'h0BADF00D, rd, lo, rl, re);
    chk("fence_hi_edge_resp", 64'(re), 64'h0);
    xfer(1'b0, 12'h200, 1'b0, 3'd2, 64'h0, rd, lo, rl, re);
    chk("fence_hi_edge_data", rd, 64'h0BADF00D);
    @(negedge clk);
    chk("wr_count_a", 64'(wrc_a), 64'd6);
    chk("rd_count_a", 64'(rdc_a), 64'd6);

    // Instance B: wait states and 64-bit aliasing
    xfer(1'b1, 12'h800, 1'b1, 3'd3, 64'h0123456789ABCDEF, rd, lo, rl, re);
    chk("b_wr_waits", 64'(lo), 64'd3);
    chk("b_wr_resp", 64'(re), 64'h0);
    xfer(1'b1, 12'h000, 1'b0, 3'd3, 64'h0, rd, lo, rl, re);
    chk("b_rd_waits", 64'(lo), 64'd3);
    chk("b_alias_data", rd, 64'h0123456789ABCDEF);

    // Write address phase held off by HREADYIN low during a read's waits
    use_b = 1'b1;
    @(posedge clk); #1;
    hsel_b = 1'b1; haddr = 12'h000; hwrite = 1'b0; hsize = 3'd3; htrans = 2'b10;
    @(posedge clk); #1;
    haddr = 12'h008; hwrite = 1'b1;
    lo = 0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (ready_b) done = 1'b1; else lo++;
    end
    chk("b2b_rd_waits", 64'(lo), 64'd3);
    chk("b2b_rd_data", rdata_b, 64'h0123456789ABCDEF);
    @(posedge clk); #1;
    hsel_b = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 64'hCAFEF00D12345678;
    lo = 0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (ready_b) done = 1'b1; else lo++;
    end
    chk("b2b_wr_waits", 64'(lo), 64'd3);
    xfer(1'b1, 12'h008, 1'b0, 3'd3, 64'h0, rd, lo, rl, re);
    chk("b2b_wr_data", rd, 64'hCAFEF00D12345678);

    // Reset during the wait of a write discards it
    use_b = 1'b1;
    @(posedge clk); #1;
    hsel_b = 1'b1; haddr = 12'h010; hwrite = 1'b1; hsize = 3'd3; htrans = 2'b10;
    @(posedge clk); #1;
    hsel_b = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = '1; rst_n = 1'b0;
    @(negedge clk);
    chk("rstw_in_wait", 64'(ready_b), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstw_ready", 64'(ready_b), 64'h1);
    chk("rstw_counts_b", {24'h0, errc_b, wrc_b, rdc_b}, 64'h0);
    chk("rstw_counts_a", {24'h0, errc_a, wrc_a, rdc_a}, 64'h0);
    xfer(1'b1, 12'h010, 1'b0, 3'd3, 64'h0, rd, lo, rl, re);
    chk("rstw_not_committed", rd, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
